// File: rtl/lebug_mem_pkg.sv
// Shared types and helpers for the trace-buffer memory arbiter.
package lebug_mem_pkg;

  typedef enum logic {INIT, RUN} arb_state_t;

  localparam int BURST_MAX = 16;

  // Minimum width 1 so a single-requester build still has a legal ID field.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate req so ptr sits at bit 0, find the first set bit, rotate the index back.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  always_comb begin
    for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
    off   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
    idx = IW'((int'(off) + int'(ptr)) % N);
    gnt = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between NUM_REQ requesters; zero-fills the RAM after reset, then grants one access per cycle.
// Optional build macro ARB_BURST_LOCK_EN adds req_lock so a requester can hold priority for up to BURST_MAX grants.
//   state | meaning
//   INIT  | zero-fill sweep over every RAM address, no grants
//   RUN   | round-robin arbitration and issue
module ram_port_arbiter
  import lebug_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = clog2(NUM_REQ),
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef ARB_BURST_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      init_done,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_q
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              init_done_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic [RD_LATENCY:0] vld_q;
  logic [ID_W-1:0]   id_q [RD_LATENCY+1];

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx, ptr_next;
  logic               pick_found, grant, rd_issue;

`ifdef ARB_BURST_LOCK_EN
  logic [3:0]      burst_q, burst_d, burst_now;
  logic            burst_act_q, burst_act_d;
  logic [ID_W-1:0] last_idx_q, last_idx_d;
`endif

  rr_priority_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign ptr_next = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (cnt_q == '1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    grant      = (state_q == RUN) && pick_found;
    gnt        = grant ? pick_gnt : '0;
    rd_issue   = grant && !req_we[pick_idx];
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
`ifdef ARB_BURST_LOCK_EN
    burst_now   = 4'd0;
    burst_d     = 4'd0;
    burst_act_d = 1'b0;
    last_idx_d  = last_idx_q;
`endif
    if (state_q == INIT) begin
      ram_wren_d = 1'b1;
      ram_data_d = '0;
      ram_addr_d = cnt_q;
      cnt_d      = cnt_q + 1'b1;
    end else if (grant) begin
      ram_addr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      ram_data_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
      ram_wren_d = req_we[pick_idx];
      ptr_d      = ptr_next;
`ifdef ARB_BURST_LOCK_EN
      // burst_now counts earlier back-to-back grants to the same requester
      burst_now   = (burst_act_q && (last_idx_q == pick_idx)) ? burst_q + 4'd1 : 4'd0;
      burst_d     = burst_now;
      burst_act_d = 1'b1;
      last_idx_d  = pick_idx;
      if (req_lock[pick_idx] && (burst_now != 4'(BURST_MAX - 1))) ptr_d = pick_idx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      vld_q       <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) id_q[i] <= '0;
`ifdef ARB_BURST_LOCK_EN
      burst_q     <= 4'd0;
      burst_act_q <= 1'b0;
      last_idx_q  <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      if (state_q == INIT && state_d == RUN) init_done_q <= 1'b1;
      vld_q[0] <= rd_issue;
      id_q[0]  <= pick_idx;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
`ifdef ARB_BURST_LOCK_EN
      burst_q     <= burst_d;
      burst_act_q <= burst_act_d;
      last_idx_q  <= last_idx_d;
`endif
    end
  end

  assign rsp_valid   = vld_q[RD_LATENCY];
  assign rsp_id      = id_q[RD_LATENCY];
  assign rsp_data    = ram_q;
  assign init_done   = init_done_q;
  assign ram_address = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one port of `ram_dual_port` between NUM_REQ requesters.
- After reset it zero-fills the whole RAM (init sweep). It then grants one read or write per cycle.
- It drives the registered RAM port signals and returns read data tagged with the requester ID after a fixed latency.
- Sits between trace/filter units and the shared memory buffer; the other RAM port stays free for readout logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)
- ADDR_W, 8, RAM address width (widthad_a)
- DATA_W, 32, RAM data width (width_a)
- RD_LATENCY, 2, RAM cycles from registered address to valid q (outdata registered, latency=1)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req  input  NUM_REQ  per-requester request, level
- req_we  input  NUM_REQ  1=write, 0=read
- req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
- rsp_valid  output  1  read data valid
- rsp_id  output  ID_W  requester owning rsp_data
- rsp_data  output  DATA_W  read data
- init_done  output  1  high once zero-fill complete
- ram_address  output  ADDR_W  to RAM address_a, registered
- ram_data  output  DATA_W  to RAM data_a, registered
- ram_wren  output  1  to RAM wren_a, registered
- ram_q  input  DATA_W  from RAM q_a

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=INIT, init counter=0, rr pointer=0, gnt=0, rsp_valid=0, rsp_id=0, init_done=0, ram_wren=0, ram_address=0, ram_data=0, read pipeline flushed.
- FSM state INIT:
  - Each cycle: ram_wren=1, ram_data=0, ram_address=counter; counter increments.
  - After address 2^ADDR_W-1 is written, go to RUN; init_done rises that cycle and stays 1 until reset.
  - gnt=0 throughout INIT. Requests are held by requesters, not dropped.
- FSM state RUN, arbitration:
  - Scan req from index ptr upward, wrapping modulo NUM_REQ; the first set bit wins.
  - gnt is one-hot or zero; at most one grant per cycle.
  - On a grant to k: ptr <= (k+1) mod NUM_REQ. With no request, ptr holds.
  - A requester sees gnt[i]=1 as acceptance and may present its next access the following cycle.
- Issue: the cycle after grant k, ram_address=addr_k, ram_wren=we_k, ram_data=wdata_k. With no grant, ram_wren=0 and address/data hold.
- Read return:
  - A read granted in cycle T gives rsp_valid=1, rsp_id=k, rsp_data=ram_q in cycle T+1+RD_LATENCY.
  - Implemented as a RD_LATENCY+1-deep valid/ID shift pipeline.
  - Back-to-back reads produce back-to-back responses in grant order.
  - Writes produce no response.
- Read-during-write: same address, consecutive cycles → the read returns the new data (RAM NEW_DATA mode); the arbiter adds no forwarding.
- Reset mid-operation: in-flight responses are discarded (rsp_valid low the next cycle), FSM returns to INIT, and the sweep restarts at address 0.
- NUM_REQ=1: grant whenever req is set; ptr stays 0.

Optional Feature:
- Macro ARB_BURST_LOCK_EN.
- Defined:
  - Extra input req_lock[NUM_REQ].
  - A granted requester with req_lock set keeps priority: ptr does not advance while req_lock[k]&req[k], up to 16 consecutive grants. After the 16th, ptr advances normally.
  - A 4-bit burst counter resets on any grant change.
- Undefined: the port is absent and arbitration is pure round-robin.

Decomposition:
- Shared package `lebug_mem_pkg`: typedef arb_state_t {INIT, RUN}; localparam BURST_MAX=16; function clog2 for ID_W.
- One sub-module `rr_priority_pick`: combinational rotate, find-first, rotate-back. Inputs req and ptr; outputs one-hot gnt and encoded index.

Test Plan:
- Reset, no requests → gnt=0 for 256 cycles (ADDR_W=8), ram_wren=1 with addresses 0..255 in order, init_done rises on cycle 256 after rst falls. A read of address 0x37 afterwards → rsp_data=0.
- After init, req=4'b1111 all reads, held 8 cycles → gnt sequence 0001,0010,0100,1000,0001,…; rsp_id sequence 0,1,2,3,… each 3 cycles after its grant.
- Requester 2 writes 0xDEADBEEF to 0x10, then requester 0 reads 0x10 next cycle → rsp_valid with rsp_id=0, rsp_data=0xDEADBEEF.
- Only req[3] asserted continuously → gnt[3]=1 every cycle; ptr wraps to 0; no starvation when req[1] joins (granted within 2 cycles).
- Assert rst while 2 reads are in flight → rsp_valid=0 from the next cycle, init_done=0, sweep restarts at address 0.
- ARB_BURST_LOCK_EN: req=4'b0011, req_lock[0]=1 → gnt[0] for 16 consecutive cycles, then gnt[1].
